// File: rtl/ex_pkg.sv
// Shared definitions for the execute stage: op codes, forwarding selects and
// the multiply/divide sequencer state type.
package ex_pkg;

  localparam int unsigned OP_W = 6;

  localparam logic [OP_W-1:0] OP_SLL   = 6'h00;
  localparam logic [OP_W-1:0] OP_SRL   = 6'h02;
  localparam logic [OP_W-1:0] OP_SRA   = 6'h03;
  localparam logic [OP_W-1:0] OP_SLLV  = 6'h04;
  localparam logic [OP_W-1:0] OP_SRLV  = 6'h06;
  localparam logic [OP_W-1:0] OP_SRAV  = 6'h07;
  localparam logic [OP_W-1:0] OP_LUI   = 6'h0f;
  localparam logic [OP_W-1:0] OP_MFHI  = 6'h10;
  localparam logic [OP_W-1:0] OP_MTHI  = 6'h11;
  localparam logic [OP_W-1:0] OP_MFLO  = 6'h12;
  localparam logic [OP_W-1:0] OP_MTLO  = 6'h13;
  localparam logic [OP_W-1:0] OP_MULT  = 6'h18;
  localparam logic [OP_W-1:0] OP_MULTU = 6'h19;
  localparam logic [OP_W-1:0] OP_DIV   = 6'h1a;
  localparam logic [OP_W-1:0] OP_DIVU  = 6'h1b;
  localparam logic [OP_W-1:0] OP_ADDU  = 6'h21;
  localparam logic [OP_W-1:0] OP_SUBU  = 6'h23;
  localparam logic [OP_W-1:0] OP_AND   = 6'h24;
  localparam logic [OP_W-1:0] OP_OR    = 6'h25;
  localparam logic [OP_W-1:0] OP_XOR   = 6'h26;
  localparam logic [OP_W-1:0] OP_NOR   = 6'h27;
  localparam logic [OP_W-1:0] OP_SLT   = 6'h2a;
  localparam logic [OP_W-1:0] OP_SLTU  = 6'h2b;

  localparam int unsigned FWD_IDEX  = 0;
  localparam int unsigned FWD_EXMEM = 1;
  localparam int unsigned FWD_MEMWB = 2;

  typedef enum logic [1:0] {
    MD_IDLE,
    MD_BUSY,
    MD_DONE
  } md_state_e;

  function automatic logic is_muldiv(input logic [OP_W-1:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_hilo(input logic [OP_W-1:0] op);
    return is_muldiv(op) || (op == OP_MFHI) || (op == OP_MFLO) ||
           (op == OP_MTHI) || (op == OP_MTLO);
  endfunction

endpackage

// File: rtl/ex_muldiv_stage_muldiv_iter.sv
// Iterative radix-2 multiply/divide unit owning the architectural HI/LO registers.
// One step per cycle on operand magnitudes, sign correction in the final cycle.
module muldiv_iter
  import ex_pkg::*;
#(
  parameter int unsigned BITS_SIZE = 32
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_valid,
  input  logic                 i_flush,
  input  logic [OP_W-1:0]      i_op,
  input  logic [BITS_SIZE-1:0] i_a,
  input  logic [BITS_SIZE-1:0] i_b,
  output logic                 o_busy,
  output logic [BITS_SIZE-1:0] o_hi,
  output logic [BITS_SIZE-1:0] o_lo
);

  localparam int unsigned W  = BITS_SIZE;
  localparam int unsigned CW = $clog2(BITS_SIZE);
  localparam logic [CW-1:0] LAST = CW'(BITS_SIZE - 1);

  md_state_e        state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [W-1:0]     a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
  logic             sgn_q, sgn_d, div_q, div_d;
  logic [2*W-1:0]   acc_q, acc_d;

  logic             issue_sgn, neg_res;
  logic [W-1:0]     mag_b, quot, rem;
  logic [W:0]       add_sum, shifted, diff;
  logic [2*W-1:0]   prod;

  // acc holds {partial product, multiplier} for MULT and {remainder, quotient}
  // for DIV, so both algorithms shift through the same 2W register.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    a_d     = a_q;
    b_d     = b_q;
    sgn_d   = sgn_q;
    div_d   = div_q;
    acc_d   = acc_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    issue_sgn = (i_op == OP_MULT) || (i_op == OP_DIV);
    mag_b     = (sgn_q && b_q[W-1]) ? -b_q : b_q;
    neg_res   = sgn_q && (a_q[W-1] ^ b_q[W-1]);
    add_sum   = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, mag_b} : '0);
    shifted   = {acc_q[2*W-1:W], acc_q[W-1]};
    diff      = shifted - {1'b0, mag_b};
    prod      = neg_res ? -acc_q : acc_q;
    quot      = neg_res ? -acc_q[W-1:0] : acc_q[W-1:0];
    rem       = (sgn_q && a_q[W-1]) ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];

    case (state_q)
      MD_IDLE: begin
        if (i_valid && !i_flush && is_muldiv(i_op)) begin
          state_d = MD_BUSY;
          count_d = '0;
          a_d     = i_a;
          b_d     = i_b;
          sgn_d   = issue_sgn;
          div_d   = (i_op == OP_DIV) || (i_op == OP_DIVU);
          acc_d   = {{W{1'b0}}, (issue_sgn && i_a[W-1]) ? -i_a : i_a};
        end else if (i_valid && (i_op == OP_MTHI)) begin
          hi_d = i_a;
        end else if (i_valid && (i_op == OP_MTLO)) begin
          lo_d = i_a;
        end
      end
      MD_BUSY: begin
        if (div_q) begin
          // diff[W] set means the trial subtraction borrowed: restore
          acc_d = diff[W] ? {shifted[W-1:0], acc_q[W-2:0], 1'b0}
                          : {diff[W-1:0], acc_q[W-2:0], 1'b1};
        end else begin
          acc_d = {add_sum, acc_q[W-1:1]};
        end
        count_d = count_q + 1'b1;
        if (count_q == LAST) state_d = MD_DONE;
      end
      MD_DONE: begin
        state_d = MD_IDLE;
        if (!div_q) begin
          {hi_d, lo_d} = prod;
        end else if (b_q == '0) begin
          hi_d = a_q;
          lo_d = '1;
        end else begin
          hi_d = rem;
          lo_d = quot;
        end
      end
      default: state_d = MD_IDLE;
    endcase

    if (i_flush && (state_q != MD_IDLE)) begin
      state_d = MD_IDLE;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= MD_IDLE;
      count_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      div_q   <= 1'b0;
      acc_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sgn_q   <= sgn_d;
      div_q   <= div_d;
      acc_q   <= acc_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  always_comb begin
    o_busy = (state_q != MD_IDLE);
    o_hi   = hi_q;
    o_lo   = lo_q;
  end

endmodule

// File: rtl/ex_muldiv_stage.sv
// Execute stage: operand forwarding, single-cycle ALU, branch-target adder and
// destination mux, with an iterative mul/div unit that stalls the front end.
module ex_muldiv_stage
  import ex_pkg::*;
#(
  parameter int unsigned BITS_SIZE          = 32,
  parameter int unsigned BITS_OP            = 6,
  parameter int unsigned BITS_REGS          = 5,
  parameter int unsigned BITS_CORTOCIRCUITO = 3
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic                          i_valid,
  input  logic                          i_flush,
  input  logic [BITS_OP-1:0]            i_alu_op,
  input  logic [BITS_REGS-1:0]          i_alu_shamt,
  input  logic                          i_flag_shamt,
  input  logic [BITS_CORTOCIRCUITO-1:0] i_corto_register_A,
  input  logic [BITS_CORTOCIRCUITO-1:0] i_corto_register_B,
  input  logic [BITS_SIZE-1:0]          i_register1,
  input  logic [BITS_SIZE-1:0]          i_register2,
  input  logic [BITS_SIZE-1:0]          i_exmem_register,
  input  logic [BITS_SIZE-1:0]          i_wb_data_write,
  input  logic [BITS_SIZE-1:0]          i_id_extension,
  input  logic                          i_idex_ctl_alu_src,
  input  logic [BITS_SIZE-1:0]          i_id_pc4,
  input  logic                          i_select_register,
  input  logic [BITS_REGS-1:0]          i_rt,
  input  logic [BITS_REGS-1:0]          i_rd,
  output logic [BITS_SIZE-1:0]          o_sum_pc_branch,
  output logic [BITS_SIZE-1:0]          o_data_register_A,
  output logic [BITS_SIZE-1:0]          o_alu_result,
  output logic                          o_alu_zero,
  output logic [BITS_REGS-1:0]          o_mux_register_rd,
  output logic                          o_stall,
  output logic [BITS_SIZE-1:0]          o_hi,
  output logic [BITS_SIZE-1:0]          o_lo
);

  localparam logic [BITS_CORTOCIRCUITO-1:0] SEL_EXMEM = BITS_CORTOCIRCUITO'(FWD_EXMEM);
  localparam logic [BITS_CORTOCIRCUITO-1:0] SEL_MEMWB = BITS_CORTOCIRCUITO'(FWD_MEMWB);

  logic [OP_W-1:0]      op;
  logic [BITS_SIZE-1:0] fwd_a, fwd_b, alu_b, alu_res;
  logic [BITS_REGS-1:0] shamt;
  logic                 md_busy;

  always_comb begin
    op = OP_W'(i_alu_op);

    case (i_corto_register_A)
      SEL_EXMEM: fwd_a = i_exmem_register;
      SEL_MEMWB: fwd_a = i_wb_data_write;
      default:   fwd_a = i_register1;
    endcase
    case (i_corto_register_B)
      SEL_EXMEM: fwd_b = i_exmem_register;
      SEL_MEMWB: fwd_b = i_wb_data_write;
      default:   fwd_b = i_register2;
    endcase

    alu_b = i_idex_ctl_alu_src ? i_id_extension : fwd_b;
    shamt = i_flag_shamt ? i_alu_shamt : fwd_a[BITS_REGS-1:0];

    alu_res = '0;
    case (op)
      OP_SLL, OP_SLLV: alu_res = alu_b << shamt;
      OP_SRL, OP_SRLV: alu_res = alu_b >> shamt;
      OP_SRA, OP_SRAV: alu_res = $signed(alu_b) >>> shamt;
      OP_LUI:          alu_res = alu_b << (BITS_SIZE / 2);
      OP_ADDU:         alu_res = fwd_a + alu_b;
      OP_SUBU:         alu_res = fwd_a - alu_b;
      OP_AND:          alu_res = fwd_a & alu_b;
      OP_OR:           alu_res = fwd_a | alu_b;
      OP_XOR:          alu_res = fwd_a ^ alu_b;
      OP_NOR:          alu_res = ~(fwd_a | alu_b);
      OP_SLT:          alu_res = BITS_SIZE'($signed(fwd_a) < $signed(alu_b));
      OP_SLTU:         alu_res = BITS_SIZE'(fwd_a < alu_b);
      OP_MFHI:         alu_res = o_hi;
      OP_MFLO:         alu_res = o_lo;
      default:         alu_res = '0;
    endcase

    o_alu_result      = alu_res;
    o_alu_zero        = (alu_res == '0);
    o_data_register_A = fwd_a;
    o_sum_pc_branch   = i_id_pc4 + (i_id_extension << 2);
    o_mux_register_rd = i_select_register ? i_rd : i_rt;
    o_stall           = md_busy | (i_valid & is_hilo(op) & md_busy);
  end

  muldiv_iter #(
    .BITS_SIZE(BITS_SIZE)
  ) u_muldiv (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .i_valid(i_valid),
    .i_flush(i_flush),
    .i_op   (op),
    .i_a    (fwd_a),
    .i_b    (fwd_b),
    .o_busy (md_busy),
    .o_hi   (o_hi),
    .o_lo   (o_lo)
  );

endmodule

// File: tb/tb_ex_muldiv_stage.sv
// Scoreboard bench for ex_muldiv_stage: stimulus pushes expectations from an
// arithmetic reference model, a negedge monitor pops and compares them.
module tb_ex_muldiv_stage;
  import ex_pkg::*;

  localparam int unsigned W = 32;

  logic         clk, rst, i_valid, i_flush, fsh_i, src_i, selr_i;
  logic [5:0]   op_i;
  logic [4:0]   sh_i, rt_i, rd_i, rd_o;
  logic [2:0]   sa_i, sb_i;
  logic [W-1:0] r1_i, r2_i, exm_i, wbd_i, ext_i, pc4_i;
  logic [W-1:0] br_o, a_o, res_o, hi_o, lo_o;
  logic         zero_o, stall_o;

  ex_muldiv_stage #(
    .BITS_SIZE(W), .BITS_OP(6), .BITS_REGS(5), .BITS_CORTOCIRCUITO(3)
  ) dut (
    .i_clk(clk), .i_reset(rst), .i_valid(i_valid), .i_flush(i_flush),
    .i_alu_op(op_i), .i_alu_shamt(sh_i), .i_flag_shamt(fsh_i),
    .i_corto_register_A(sa_i), .i_corto_register_B(sb_i),
    .i_register1(r1_i), .i_register2(r2_i), .i_exmem_register(exm_i),
    .i_wb_data_write(wbd_i), .i_id_extension(ext_i), .i_idex_ctl_alu_src(src_i),
    .i_id_pc4(pc4_i), .i_select_register(selr_i), .i_rt(rt_i), .i_rd(rd_i),
    .o_sum_pc_branch(br_o), .o_data_register_A(a_o), .o_alu_result(res_o),
    .o_alu_zero(zero_o), .o_mux_register_rd(rd_o), .o_stall(stall_o),
    .o_hi(hi_o), .o_lo(lo_o)
  );

  typedef struct {
    bit           chk;
    logic [W-1:0] res, opa, br;
    logic [4:0]   rd;
  } alu_exp_t;
  typedef struct {
    logic [W-1:0] hi, lo;
    int unsigned  len;
  } hl_exp_t;

  alu_exp_t    alu_q[$];
  hl_exp_t     hl_q[$];
  int unsigned n_cmp = 0, n_bad = 0;
  logic [W-1:0] m_hi = '0, m_lo = '0;
  int unsigned stall_cnt = 0;
  bit          prev_stall = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [W-1:0] fwd(input logic [2:0] s, input logic [W-1:0] r,
                                       input logic [W-1:0] e, input logic [W-1:0] w);
    if (s == 3'd1) return e;
    if (s == 3'd2) return w;
    return r;
  endfunction

  function automatic logic [W-1:0] alu_model(input logic [5:0] op, input logic [W-1:0] a,
                                             input logic [W-1:0] b, input int unsigned s);
    longint signed   sb64 = longint'($signed(b));
    longint unsigned ub64 = longint'(b);
    case (op)
      OP_SLL, OP_SLLV: return W'(ub64 << s);
      OP_SRL, OP_SRLV: return W'(ub64 >> s);
      OP_SRA, OP_SRAV: return W'(sb64 >>> s);
      OP_LUI:          return W'(ub64 * (64'd1 << (W / 2)));
      OP_ADDU:         return W'(longint'(a) + ub64);
      OP_SUBU:         return W'(longint'(a) - ub64);
      OP_AND:          return a & b;
      OP_OR:           return a | b;
      OP_XOR:          return a ^ b;
      OP_NOR:          return ~(a | b);
      OP_SLT:          return (longint'($signed(a)) < sb64) ? W'(1) : W'(0);
      OP_SLTU:         return (longint'(a) < ub64) ? W'(1) : W'(0);
      default:         return '0;
    endcase
  endfunction

  // Returns {HI, LO} from plain signed/unsigned arithmetic at double width.
  function automatic logic [2*W-1:0] md_model(input logic [5:0] op, input logic [W-1:0] a,
                                              input logic [W-1:0] b);
    logic signed [2*W-1:0] sa, sb, q, r;
    bit s = (op == OP_MULT) || (op == OP_DIV);
    sa = s ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
    sb = s ? {{W{b[W-1]}}, b} : {{W{1'b0}}, b};
    if (op == OP_MULT || op == OP_MULTU) return sa * sb;
    if (b == '0) return {a, {W{1'b1}}};
    q = sa / sb;
    r = sa % sb;
    return {r[W-1:0], q[W-1:0]};
  endfunction

  // Drives one instruction, queues its expectations, waits until accepted.
  task automatic exec(input logic [5:0] op, input logic [W-1:0] r1, input logic [W-1:0] r2,
                      input logic [W-1:0] exm, input logic [W-1:0] wbd, input logic [W-1:0] ext,
                      input logic [2:0] sa, input logic [2:0] sb, input bit src, input bit fsh,
                      input logic [4:0] sh, input bit track);
    logic [W-1:0]   fa, fb, bop, res, pc4;
    logic [2*W-1:0] hl;
    logic [4:0]     rt, rd;
    bit             sel, acc;
    rt = 5'($urandom); rd = 5'($urandom); sel = 1'($urandom); pc4 = W'($urandom);
    op_i = op; r1_i = r1; r2_i = r2; exm_i = exm; wbd_i = wbd; ext_i = ext;
    sa_i = sa; sb_i = sb; src_i = src; fsh_i = fsh; sh_i = sh;
    rt_i = rt; rd_i = rd; selr_i = sel; pc4_i = pc4; i_valid = 1'b1;
    fa  = fwd(sa, r1, exm, wbd);
    fb  = fwd(sb, r2, exm, wbd);
    bop = src ? ext : fb;
    if (op == OP_MFHI)      res = m_hi;
    else if (op == OP_MFLO) res = m_lo;
    else                    res = alu_model(op, fa, bop, fsh ? int'(sh) : int'(fa[4:0]));
    alu_q.push_back('{chk: !is_muldiv(op) && op != OP_MTHI && op != OP_MTLO,
                      res: res, opa: fa, br: W'(pc4 + (ext << 2)), rd: sel ? rd : rt});
    if (track && is_muldiv(op)) begin
      hl = md_model(op, fa, fb);
      hl_q.push_back('{hi: hl[2*W-1:W], lo: hl[W-1:0], len: W + 1});
      m_hi = hl[2*W-1:W];
      m_lo = hl[W-1:0];
    end
    if (op == OP_MTHI) m_hi = fa;
    if (op == OP_MTLO) m_lo = fa;
    acc = 1'b0;
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clk);
      acc = (stall_o !== 1'b1);
    end
    if (!acc) chk("accept_timeout", 64'(stall_o), 64'd0);
    @(posedge clk); #1;
    i_valid = 1'b0;
  endtask

  task automatic rand_alu();
    logic [5:0] ops [15] = '{OP_SLL, OP_SRL, OP_SRA, OP_SLLV, OP_SRLV, OP_SRAV, OP_LUI,
                             OP_ADDU, OP_SUBU, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLT, OP_SLTU};
    exec(ops[$urandom_range(14)], W'($urandom), W'($urandom), W'($urandom), W'($urandom),
         W'($urandom), 3'($urandom_range(7)), 3'($urandom_range(7)), 1'($urandom),
         1'($urandom), 5'($urandom), 1'b1);
  endtask

  task automatic rand_md();
    logic [5:0]   ops [4] = '{OP_MULT, OP_MULTU, OP_DIV, OP_DIVU};
    logic [W-1:0] a, b;
    a = ($urandom_range(5) == 0) ? {1'b1, {(W-1){1'b0}}} : W'($urandom);
    case ($urandom_range(3))
      0:       b = '0;
      1:       b = W'($urandom_range(15, 1));
      2:       b = '1;
      default: b = W'($urandom);
    endcase
    exec(ops[$urandom_range(3)], a, b, W'($urandom), W'($urandom), W'($urandom),
         3'd0, 3'd0, 1'b0, 1'b0, 5'd0, 1'b1);
    if ($urandom_range(1) == 1)
      exec($urandom_range(1) ? OP_MFHI : OP_MFLO, '0, '0, '0, '0, W'($urandom),
           3'd0, 3'd0, 1'b0, 1'b0, 5'd0, 1'b1);
  endtask

  always @(negedge clk) begin
    alu_exp_t e;
    hl_exp_t  h;
    if (stall_o === 1'b1) begin
      stall_cnt++;
    end else begin
      if (prev_stall) begin
        if (hl_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL hilo_unexpected: stall fell with hi=%h lo=%h, expected no completion", hi_o, lo_o);
        end else begin
          h = hl_q.pop_front();
          chk("hi", 64'(hi_o), 64'(h.hi));
          chk("lo", 64'(lo_o), 64'(h.lo));
          if (h.len != 0) chk("stall_len", 64'(stall_cnt), 64'(h.len));
        end
      end
      stall_cnt = 0;
      if (i_valid && !rst) begin
        if (alu_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL alu_unexpected: accepted op %h with no expectation queued", op_i);
        end else begin
          e = alu_q.pop_front();
          chk("opA", 64'(a_o), 64'(e.opa));
          chk("branch", 64'(br_o), 64'(e.br));
          chk("rd_mux", 64'(rd_o), 64'(e.rd));
          if (e.chk) begin
            chk("alu_result", 64'(res_o), 64'(e.res));
            chk("alu_zero", 64'(zero_o), 64'(e.res == '0));
          end
        end
      end
    end
    prev_stall = (stall_o === 1'b1);
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time %0t exceeded limit", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] x;
    rst = 1'b1; i_valid = 1'b0; i_flush = 1'b0; op_i = '0; sh_i = '0; fsh_i = 1'b0;
    sa_i = '0; sb_i = '0; r1_i = '0; r2_i = '0; exm_i = '0; wbd_i = '0; ext_i = '0;
    src_i = 1'b0; pc4_i = '0; selr_i = 1'b0; rt_i = '0; rd_i = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_stall", 64'(stall_o), 64'd0);
    chk("reset_hi", 64'(hi_o), 64'd0);
    chk("reset_lo", 64'(lo_o), 64'd0);
    @(posedge clk); #1;

    exec(OP_ADDU, W'($urandom), W'(5), W'(7), W'($urandom), W'($urandom), 3'd1, 3'd0, 1'b0, 1'b0, 5'd0, 1'b1);
    x = W'($urandom);
    exec(OP_SUBU, x, x, '0, '0, W'($urandom), 3'd0, 3'd0, 1'b0, 1'b0, 5'd0, 1'b1);

    exec(OP_MULT, -W'(3), W'(5), '0, '0, '0, 3'd0, 3'd0, 1'b0, 1'b0, 5'd0, 1'b1);
    exec(OP_MFLO, '0, '0, '0, '0, '0, 3'd0, 3'd0, 1'b0, 1'b0, 5'd0, 1'b1);
    exec(OP_MFHI, '0, '0, '0, '0, '0, 3'd0, 3'd0, 1'b0, 1'b0, 5'd0, 1'b1);

    exec(OP_MULT, W'($urandom), W'($urandom), '0, '0, '0, 3'd0, 3'd0, 1'b0, 1'b0, 5'd0, 1'b1);
    repeat (2) begin @(posedge clk); #1; end
    exec(OP_MFHI, '0, '0, '0, '0, '0, 3'd0, 3'd0, 1'b0, 1'b0, 5'd0, 1'b1);

    exec(OP_DIVU, W'(100), W'(7), '0, '0, '0, 3'd0, 3'd0, 1'b0, 1'b0, 5'd0, 1'b1);
    exec(OP_DIV, -W'(7), W'(2), '0, '0, '0, 3'd0, 3'd0, 1'b0, 1'b0, 5'd0, 1'b1);
    exec(OP_DIV, W'(5), W'(0), '0, '0, '0, 3'd0, 3'd0, 1'b0, 1'b0, 5'd0, 1'b1);
    exec(OP_DIV, {1'b1, {(W-1){1'b0}}}, '1, '0, '0, '0, 3'd0, 3'd0, 1'b0, 1'b0, 5'd0, 1'b1);

    // DIV squashed in its 10th stalled cycle: HI/LO stay at the previous result
    exec(OP_DIV, W'($urandom), W'(3), '0, '0, '0, 3'd0, 3'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    hl_q.push_back('{hi: m_hi, lo: m_lo, len: 10});
    repeat (9) @(posedge clk);
    #1 i_flush = 1'b1;
    @(posedge clk);
    #1 i_flush = 1'b0;

    i_flush = 1'b1;
    exec(OP_MULTU, W'($urandom), W'($urandom), '0, '0, '0, 3'd0, 3'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    i_flush = 1'b0;
    @(negedge clk);
    chk("flush_issue_stall", 64'(stall_o), 64'd0);
    chk("flush_issue_hi", 64'(hi_o), 64'(m_hi));
    chk("flush_issue_lo", 64'(lo_o), 64'(m_lo));
    @(posedge clk); #1;

    exec(OP_MTHI, W'($urandom) | W'(1), '0, '0, '0, '0, 3'd0, 3'd0, 1'b0, 1'b0, 5'd0, 1'b1);
    exec(OP_MTLO, '0, '0, W'($urandom) | W'(1), '0, '0, 3'd1, 3'd0, 1'b0, 1'b0, 5'd0, 1'b1);
    exec(OP_MFHI, '0, '0, '0, '0, '0, 3'd0, 3'd0, 1'b0, 1'b0, 5'd0, 1'b1);
    exec(OP_MFLO, '0, '0, '0, '0, '0, 3'd0, 3'd0, 1'b0, 1'b0, 5'd0, 1'b1);

    exec(OP_MULTU, W'($urandom), W'($urandom), '0, '0, '0, 3'd0, 3'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    hl_q.push_back('{hi: '0, lo: '0, len: 5});
    m_hi = '0;
    m_lo = '0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    exec(OP_MFHI, '0, '0, '0, '0, '0, 3'd0, 3'd0, 1'b0, 1'b0, 5'd0, 1'b1);
    exec(OP_MFLO, '0, '0, '0, '0, '0, 3'd0, 3'd0, 1'b0, 1'b0, 5'd0, 1'b1);

    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(4) == 0) rand_md();
      else rand_alu();
    end

    repeat (W + 8) @(posedge clk);
    @(negedge clk);
    chk("alu_queue_drained", 64'(alu_q.size()), 64'd0);
    chk("hilo_queue_drained", 64'(hl_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
